vga_pattern_gen: RTL and testbench

//  Parametrised VGA test-pattern generator: own timing counters, four runtime-selectable patterns,

---
 rtl/vga_pattern_pkg.sv | 34 +++
 rtl/vga_timing.sv | 66 ++++++
 rtl/vga_pattern_gen.sv | 197 +++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA test-pattern generator: pattern mode codes,
// default 640x480@60 timing and colour-level helpers.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_RAMP    = 2'd2,
    MODE_GRID    = 2'd3
  } mode_e;

  localparam int DEF_CDEPTH  = 4;
  localparam int DEF_HACTIVE = 640;
  localparam int DEF_HFRONT  = 16;
  localparam int DEF_HWIDTH  = 96;
  localparam int DEF_HBACK   = 48;
  localparam int DEF_VACTIVE = 480;
  localparam int DEF_VFRONT  = 10;
  localparam int DEF_VWIDTH  = 2;
  localparam int DEF_VBACK   = 33;
  localparam int DEF_CHK     = 32;

  localparam int MAX_CDEPTH  = 16;

  // Full-scale level for a channel of the given depth, right-aligned.
  function automatic logic [MAX_CDEPTH-1:0] colour_white(input int cdepth);
    return MAX_CDEPTH'((64'd1 << cdepth) - 64'd1);
  endfunction

  function automatic logic [MAX_CDEPTH-1:0] colour_black();
    return '0;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with combinational sync, active-area
// and end-of-frame decode; everything advances only on the pixel strobe.
module vga_timing
  import vga_pattern_pkg::*;
#(
  parameter int HACTIVE = DEF_HACTIVE,
  parameter int HFRONT  = DEF_HFRONT,
  parameter int HWIDTH  = DEF_HWIDTH,
  parameter int HBACK   = DEF_HBACK,
  parameter int VACTIVE = DEF_VACTIVE,
  parameter int VFRONT  = DEF_VFRONT,
  parameter int VWIDTH  = DEF_VWIDTH,
  parameter int VBACK   = DEF_VBACK,
  localparam int HTOTAL = HACTIVE + HFRONT + HWIDTH + HBACK,
  localparam int VTOTAL = VACTIVE + VFRONT + VWIDTH + VBACK,
  localparam int HW     = $clog2(HTOTAL),
  localparam int VW     = $clog2(VTOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pck_en,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hs_n,
  output logic          vs_n,
  output logic          active,
  output logic          frame_end
);

  localparam logic [HW-1:0] H_ACT   = HW'(HACTIVE);
  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] HS_BEG  = HW'(HACTIVE + HFRONT);
  localparam logic [HW-1:0] HS_END  = HW'(HACTIVE + HFRONT + HWIDTH);
  localparam logic [VW-1:0] V_ACT   = VW'(VACTIVE);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] VS_BEG  = VW'(VACTIVE + VFRONT);
  localparam logic [VW-1:0] VS_END  = VW'(VACTIVE + VFRONT + VWIDTH);

  logic h_last;
  logic v_last;

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pck_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign hs_n      = !((hcnt >= HS_BEG) && (hcnt < HS_END));
  assign vs_n      = !((vcnt >= VS_BEG) && (vcnt < VS_END));
  assign active    = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign frame_end = h_last && v_last;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: raster timing, four frame-synchronous patterns
// and a two-stage output pipeline. Define PATTERN_SCROLL_EN to scroll left 1 px/frame.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int CDEPTH  = DEF_CDEPTH,
  parameter int HACTIVE = DEF_HACTIVE,
  parameter int HFRONT  = DEF_HFRONT,
  parameter int HWIDTH  = DEF_HWIDTH,
  parameter int HBACK   = DEF_HBACK,
  parameter int VACTIVE = DEF_VACTIVE,
  parameter int VFRONT  = DEF_VFRONT,
  parameter int VWIDTH  = DEF_VWIDTH,
  parameter int VBACK   = DEF_VBACK,
  parameter int CHK     = DEF_CHK
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PCK_EN,
  input  logic [1:0]        MODE,
  output logic [CDEPTH-1:0] VGA_R,
  output logic [CDEPTH-1:0] VGA_G,
  output logic [CDEPTH-1:0] VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_DE,
  output logic              FRAME_START
);

  localparam int HTOTAL = HACTIVE + HFRONT + HWIDTH + HBACK;
  localparam int VTOTAL = VACTIVE + VFRONT + VWIDTH + VBACK;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int CB     = $clog2(CHK);

  localparam logic [CDEPTH-1:0] WHITE = CDEPTH'(colour_white(CDEPTH));
  localparam logic [CDEPTH-1:0] BLACK = CDEPTH'(colour_black());

  typedef struct packed {
    logic [CDEPTH-1:0] r;
    logic [CDEPTH-1:0] g;
    logic [CDEPTH-1:0] b;
    logic              de;
    logic              hs_n;
    logic              vs_n;
    logic              first;
  } pix_t;

  localparam pix_t PIX_RST = '{r: '0, g: '0, b: '0, de: 1'b0,
                               hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hs_n;
  logic          vs_n;
  logic          active;
  logic          frame_end;

  vga_timing #(
    .HACTIVE (HACTIVE), .HFRONT (HFRONT), .HWIDTH (HWIDTH), .HBACK (HBACK),
    .VACTIVE (VACTIVE), .VFRONT (VFRONT), .VWIDTH (VWIDTH), .VBACK (VBACK)
  ) u_timing (
    .clk       (CLK),
    .rst       (RST),
    .pck_en    (PCK_EN),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .hs_n      (hs_n),
    .vs_n      (vs_n),
    .active    (active),
    .frame_end (frame_end)
  );

  mode_e         mode_q;
  logic [HW-1:0] x;
  logic [VW-1:0] y;

  assign y = vcnt;

`ifdef PATTERN_SCROLL_EN
  localparam int SW   = 10;
  localparam int SUMW = ((HW > SW) ? HW : SW) + 1;

  logic [SW-1:0]   scroll_q;
  logic [SUMW-1:0] x_sum;

  // hcnt and the offset are each below HACTIVE in the visible area, so one
  // conditional subtract is a complete mod HACTIVE.
  assign x_sum = SUMW'(hcnt) + SUMW'(scroll_q);
  assign x     = (x_sum >= SUMW'(HACTIVE)) ? HW'(x_sum - SUMW'(HACTIVE)) : HW'(x_sum);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      scroll_q <= '0;
    end else if (PCK_EN && frame_end) begin
      scroll_q <= (scroll_q == SW'(HACTIVE - 1)) ? '0 : scroll_q + 1'b1;
    end
  end
`else
  assign x = hcnt;
`endif

  logic [HW+2:0]        bar_full;
  logic [2:0]           bar;
  logic [VW+1:0]        band_full;
  logic                 band_odd;
  logic [2:0]           bar_idx;
  logic [HW+CDEPTH-1:0] ramp_full;
  logic [CDEPTH-1:0]    ramp;
  logic                 chk_black;
  logic                 grid_on;

  assign bar_full  = {x, 3'b000} / (HW+3)'(HACTIVE);
  assign bar       = (bar_full > (HW+3)'(7)) ? 3'd7 : bar_full[2:0];
  assign band_full = {y, 2'b00} / (VW+2)'(VACTIVE);
  assign band_odd  = |(band_full & (VW+2)'(1));
  assign bar_idx   = band_odd ? 3'd7 - bar : bar;

  assign ramp_full = {x, {CDEPTH{1'b0}}} / (HW+CDEPTH)'(HACTIVE);
  assign ramp      = (ramp_full > (HW+CDEPTH)'(2**CDEPTH - 1)) ? WHITE : ramp_full[CDEPTH-1:0];

  assign chk_black = x[CB] ^ y[CB];
  assign grid_on   = ((x & HW'(CHK - 1)) == '0) || ((y & VW'(CHK - 1)) == '0) ||
                     (x == HW'(HACTIVE - 1)) || (y == VW'(VACTIVE - 1));

  pix_t pat;
  pix_t s1;

  // NOTE: pat gets a full default before the case so no path leaves a field
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pat       = PIX_RST;
    pat.de    = active;
    pat.hs_n  = hs_n;
    pat.vs_n  = vs_n;
    pat.first = active && (hcnt == '0) && (vcnt == '0);
    case (mode_q)
      MODE_BARS: begin
        pat.r = {CDEPTH{bar_idx[2]}};
        pat.g = {CDEPTH{bar_idx[1]}};
        pat.b = {CDEPTH{bar_idx[0]}};
      end
      MODE_CHECKER: begin
        pat.r = chk_black ? BLACK : WHITE;
        pat.g = chk_black ? BLACK : WHITE;
        pat.b = chk_black ? BLACK : WHITE;
      end
      MODE_RAMP: begin
        pat.r = ramp;
        pat.g = ramp;
        pat.b = ramp;
      end
      MODE_GRID: begin
        pat.r = grid_on ? WHITE : BLACK;
        pat.g = grid_on ? WHITE : BLACK;
        pat.b = grid_on ? WHITE : BLACK;
      end
    endcase
  end

  // Mode is only taken on the last pixel of a frame, so a frame never mixes patterns.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q <= MODE_BARS;
      s1     <= PIX_RST;
    end else if (PCK_EN) begin
      s1 <= pat;
      if (frame_end) begin
        mode_q <= mode_e'(MODE);
      end
    end
  end

  // FRAME_START is a one-CLK pulse, so unlike the other outputs it is not held.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_DE      <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= PCK_EN && s1.first;
      if (PCK_EN) begin
        VGA_R  <= s1.de ? s1.r : BLACK;
        VGA_G  <= s1.de ? s1.g : BLACK;
        VGA_B  <= s1.de ? s1.b : BLACK;
        VGA_HS <= s1.hs_n;
        VGA_VS <= s1.vs_n;
        VGA_DE <= s1.de;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen on a reduced 64x16 raster (80x20 total)
// so that several whole frames fit in a short run.
module tb_vga_pattern_gen;
  import vga_pattern_pkg::*;

  localparam int CDEPTH = 4;
  localparam int HACT = 64, HFP = 4, HSW = 8, HBP = 4;
  localparam int VACT = 16, VFP = 1, VSW = 2, VBP = 1;
  localparam int CHK  = 8;
  localparam int HT   = HACT + HFP + HSW + HBP;
  localparam int VT   = VACT + VFP + VSW + VBP;
  localparam int BUDGET = 20000;
`ifdef PATTERN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic              CLK;
  logic              RST;
  logic              PCK_EN;
  logic [1:0]        MODE;
  logic [CDEPTH-1:0] VGA_R, VGA_G, VGA_B;
  logic              VGA_HS, VGA_VS, VGA_DE, FRAME_START;
  logic [11:0]       rgb;

  assign rgb = {VGA_R, VGA_G, VGA_B};

  vga_pattern_gen #(
    .CDEPTH (CDEPTH), .HACTIVE (HACT), .HFRONT (HFP), .HWIDTH (HSW), .HBACK (HBP),
    .VACTIVE (VACT), .VFRONT (VFP), .VWIDTH (VSW), .VBACK (VBP), .CHK (CHK)
  ) dut (
    .CLK (CLK), .RST (RST), .PCK_EN (PCK_EN), .MODE (MODE),
    .VGA_R (VGA_R), .VGA_G (VGA_G), .VGA_B (VGA_B),
    .VGA_HS (VGA_HS), .VGA_VS (VGA_VS), .VGA_DE (VGA_DE),
    .FRAME_START (FRAME_START)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int h;
    int v;
    int f;
    bit valid;
  } pos_t;

  // cur models the raster counters; p1/p2 are the two pipeline stages, so p2
  // is the pixel currently on the outputs.
  pos_t cur, p1, p2;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   duty  = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = '{h: 0, v: 0, f: 0, valid: 1'b1};
    p1.valid = 1'b0;
    p2.valid = 1'b0;
  endtask

  task automatic tick();
    bit strobe;
    strobe = PCK_EN;
    @(posedge CLK);
    if (strobe && !RST) begin
      p2 = p1;
      p1 = cur;
      cur.h = cur.h + 1;
      if (cur.h == HT) begin
        cur.h = 0;
        cur.v = cur.v + 1;
        if (cur.v == VT) begin
          cur.v = 0;
          cur.f = cur.f + 1;
        end
      end
    end
    #1;
    cyc++;
    PCK_EN = ((cyc % duty) == 0);
  endtask

  task automatic wait_hv(input int f, input int h, input int v);
    int n;
    bit hit;
    n = 0;
    hit = p2.valid && p2.f == f && p2.h == h && p2.v == v;
    while (!hit && n < BUDGET) begin
      tick();
      n++;
      hit = p2.valid && p2.f == f && p2.h == h && p2.v == v;
    end
    if (!hit) begin
      tests++;
      fails++;
      $error("FAIL wait_f%0d_h%0d_v%0d: pixel not reached, observed timeout, expected arrival", f, h, v);
    end
  endtask

  // Wait for the pixel whose pattern x-coordinate is x (accounts for scrolling).
  task automatic wait_xy(input int f, input int x, input int y);
    int h;
    h = SCROLL ? ((((x - f) % HACT) + HACT) % HACT) : x;
    wait_hv(f, h, y);
  endtask

  initial begin
    RST    = 1'b1;
    PCK_EN = 1'b1;
    MODE   = MODE_BARS;
    model_reset();
    #3;
    check("rst_rgb", rgb, 12'h000);
    check("rst_hs", VGA_HS, 1);
    check("rst_vs", VGA_VS, 1);
    check("rst_de", VGA_DE, 0);
    check("rst_fs", FRAME_START, 0);
    tick();
    tick();
    RST = 1'b0;

    // One strobe after release: stage 1 holds (0,0), outputs still idle.
    tick();
    check("lat1_de", VGA_DE, 0);
    check("lat1_fs", FRAME_START, 0);
    wait_hv(0, 0, 0);
    check("f0_fs", FRAME_START, 1);
    check("f0_de", VGA_DE, 1);
    check("bars_0_0", rgb, 12'h000);
    wait_xy(0, 1, 0);
    check("fs_width", FRAME_START, 0);
    wait_xy(0, 8, 0);
    check("bars_8_0", rgb, 12'h00F);
    wait_xy(0, 30, 0);
    check("bars_30_0", rgb, 12'h0FF);

    // Asynchronous reset in the middle of a line.
    #2;
    RST = 1'b1;
    #1;
    check("mr_rgb", rgb, 12'h000);
    check("mr_de", VGA_DE, 0);
    check("mr_hs", VGA_HS, 1);
    check("mr_vs", VGA_VS, 1);
    check("mr_fs", FRAME_START, 0);
    model_reset();
    tick();
    tick();
    RST = 1'b0;

    wait_hv(0, 0, 0);
    check("mr_f0_fs", FRAME_START, 1);
    wait_xy(0, 56, 0);
    check("bars_56_0", rgb, 12'hFFF);
    wait_xy(0, 63, 0);
    check("bars_63_0", rgb, 12'hFFF);
    wait_hv(0, 64, 0);
    check("hblank_rgb", rgb, 12'h000);
    check("hblank_de", VGA_DE, 0);
    wait_hv(0, 67, 0);
    check("hs_67", VGA_HS, 1);
    wait_hv(0, 68, 0);
    check("hs_68", VGA_HS, 0);
    wait_hv(0, 75, 0);
    check("hs_75", VGA_HS, 0);
    wait_hv(0, 76, 0);
    check("hs_76", VGA_HS, 1);
    wait_xy(0, 0, 4);
    check("bars_inv_0_4", rgb, 12'hFFF);
    check("de_0_4", VGA_DE, 1);
    wait_hv(0, 0, 16);
    check("vblank_de", VGA_DE, 0);
    check("vs_16", VGA_VS, 1);
    wait_hv(0, 0, 17);
    check("vs_17", VGA_VS, 0);
    wait_hv(0, 79, 18);
    check("vs_18", VGA_VS, 0);
    wait_hv(0, 0, 19);
    check("vs_19", VGA_VS, 1);
    wait_hv(1, 0, 0);
    check("f1_fs", FRAME_START, 1);

    // Mode written mid-frame: current frame keeps bars, next frame ramps.
    wait_xy(1, 0, 8);
    MODE = MODE_RAMP;
    wait_xy(1, 8, 10);
    check("still_bars_8_10", rgb, 12'h00F);
    wait_xy(2, 4, 0);
    check("ramp_4", rgb, 12'h111);
    wait_xy(2, 32, 0);
    check("ramp_32", rgb, 12'h888);
    wait_xy(2, 63, 0);
    check("ramp_63", rgb, 12'hFFF);
    wait_xy(2, 0, 5);
    MODE = MODE_CHECKER;

    wait_xy(3, 0, 0);
    check("chk_0_0", rgb, 12'hFFF);
    wait_xy(3, 8, 1);
    check("chk_8_1", rgb, 12'h000);
    wait_xy(3, 8, 8);
    check("chk_8_8", rgb, 12'hFFF);
    wait_hv(3, 64, 8);
    check("chk_blank_rgb", rgb, 12'h000);
    check("chk_blank_de", VGA_DE, 0);
    MODE = MODE_GRID;

    wait_xy(4, 0, 1);
    check("grid_0_1", rgb, 12'hFFF);
    wait_xy(4, 1, 1);
    check("grid_1_1", rgb, 12'h000);
    wait_hv(4, 4, 2);
`ifdef PATTERN_SCROLL_EN
    check("grid_raw_4_2", rgb, 12'hFFF);
`else
    check("grid_raw_4_2", rgb, 12'h000);
`endif
    wait_xy(4, 8, 3);
    check("grid_8_3", rgb, 12'hFFF);
    wait_xy(4, 63, 3);
    check("grid_63_3", rgb, 12'hFFF);
    wait_xy(4, 5, 8);
    check("grid_5_8", rgb, 12'hFFF);
    wait_xy(4, 5, 9);
    check("grid_5_9", rgb, 12'h000);
    wait_xy(4, 5, 15);
    check("grid_5_15", rgb, 12'hFFF);

    // Quarter-rate pixel strobe.
    duty = 4;
    wait_hv(5, 0, 0);
    check("q_fs", FRAME_START, 1);
    check("q_de", VGA_DE, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("q_fs_low", FRAME_START, 0);
      check("q_de_hold", VGA_DE, 1);
    end
    wait_xy(5, 0, 1);
    check("q_grid_0_1", rgb, 12'hFFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("q_hold_rgb", rgb, 12'hFFF);
    end
    wait_xy(5, 1, 1);
    check("q_grid_1_1", rgb, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
